// File: rtl/ro_puf_pkg.sv
// -----------------------------------------------------------------------------
// ro_puf_pkg
//   Shared definitions for the ring-oscillator PUF measurement engine:
//   - state_t        : measurement FSM state encoding
//   - SETTLE_CYCLES  : cycles spent flushing the mux/synchroniser after a
//                      pair switch before edges are counted
//   - pair_index()   : oscillator index of pair member k for a given base
// -----------------------------------------------------------------------------
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Three cycles cover the two synchroniser flops plus the edge-detect flop,
    // so the first MEASURE cycle sees only samples of the newly selected RO.
    localparam int unsigned SETTLE_CYCLES = 3;

    // (base + k) mod num_ro; num_ro is a power of two, so a mask suffices.
    function automatic logic [31:0] pair_index(input logic [31:0] base,
                                               input logic [31:0] k,
                                               input logic [31:0] num_ro);
        return (base + k) & (num_ro - 32'd1);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// -----------------------------------------------------------------------------
// ro_edge_counter
//   One measurement channel: selects an oscillator, synchronises it into the
//   clk domain, detects rising edges and counts them with saturation.
//
//   Ports:
//     clk     in   system clock
//     rst_n   in   asynchronous reset, active-high
//     ro_in   in   NUM_RO oscillator outputs (asynchronous to clk)
//     sel     in   SEL_W  oscillator select
//     clear   in   synchronous counter clear (has priority over enable)
//     enable  in   count detected edges while high
//     count   out  CNT_W  saturating edge count
// -----------------------------------------------------------------------------
module ro_edge_counter #(
    parameter int NUM_RO = 16,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              clear,
    input  logic              enable,
    output logic [CNT_W-1:0]  count
);

    logic mux_out;
    logic sync1;
    logic sync2;
    logic sync3;
    logic rise;

    assign mux_out = ro_in[sel];

    // sync1/sync2 resolve metastability; sync3 is the previous sync2 sample.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= mux_out;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    // Holds at all-ones instead of wrapping so an overflowing count can never
    // compare smaller than a slower oscillator.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && rise && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_puf_engine.sv
// -----------------------------------------------------------------------------
// ro_puf_engine
//   Ring-oscillator PUF measurement engine. A challenge selects a base pair
//   (sel_a, sel_b); response bit k compares the edge counts of oscillators
//   sel_a+k and sel_b+k (mod NUM_RO) over a programmable window.
//
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous reset, active-high (despite the suffix)
//     ro_in       in   NUM_RO free-running oscillator outputs
//     start       in   request pulse, honoured only in IDLE
//     challenge   in   {sel_b, sel_a}, latched on accepted start
//     window      in   measurement length in clk cycles (0 behaves as 1)
//     busy        out  high from the cycle after accepted start through DONE
//     resp_valid  out  one-cycle pulse in DONE
//     response    out  bit k = (count A > count B) for pair k
//     tie_mask    out  bit k = (count A == count B) for pair k
//     cnt_a_last  out  final count of oscillator A for the latest bit
//     cnt_b_last  out  final count of oscillator B for the latest bit
// -----------------------------------------------------------------------------
module ro_puf_engine
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO    = 16,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RO-1:0]    ro_in,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    input  logic [WIN_W-1:0]     window,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [RESP_BITS-1:0] response,
    output logic [RESP_BITS-1:0] tie_mask,
    output logic [CNT_W-1:0]     cnt_a_last,
    output logic [CNT_W-1:0]     cnt_b_last
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    state_t           state;
    logic [1:0]       settle_cnt;
    logic [WIN_W-1:0] win_len;
    logic [WIN_W-1:0] win_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [SEL_W-1:0] sel_a_base;
    logic [SEL_W-1:0] sel_b_base;
    logic [SEL_W-1:0] sel_a_cur;
    logic [SEL_W-1:0] sel_b_cur;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             last_bit;

    assign sel_a_cur = SEL_W'(pair_index(32'(sel_a_base), 32'(bit_idx), 32'(NUM_RO)));
    assign sel_b_cur = SEL_W'(pair_index(32'(sel_b_base), 32'(bit_idx), 32'(NUM_RO)));

    // The mux moves to the new pair on entry to SETTLE; counters are held at
    // zero there so glitches from the switch never reach a count.
    assign cnt_clear  = (state == SETTLE);
    assign cnt_enable = (state == MEASURE);
    assign last_bit   = (bit_idx == IDX_W'(RESP_BITS - 1));

    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    ro_edge_counter #(
        .NUM_RO (NUM_RO),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_in  (ro_in),
        .sel    (sel_a_cur),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt_a)
    );

    ro_edge_counter #(
        .NUM_RO (NUM_RO),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_in  (ro_in),
        .sel    (sel_b_cur),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt_b)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            win_len    <= '0;
            win_cnt    <= '0;
            bit_idx    <= '0;
            sel_a_base <= '0;
            sel_b_base <= '0;
            response   <= '0;
            tie_mask   <= '0;
            cnt_a_last <= '0;
            cnt_b_last <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        sel_a_base <= challenge[SEL_W-1:0];
                        sel_b_base <= challenge[2*SEL_W-1:SEL_W];
                        win_len    <= (window == '0) ? WIN_W'(1) : window;
                        bit_idx    <= '0;
                        settle_cnt <= '0;
                        response   <= '0;
                        tie_mask   <= '0;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == 2'(SETTLE_CYCLES - 1)) begin
                        state      <= MEASURE;
                        settle_cnt <= '0;
                        win_cnt    <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end

                MEASURE: begin
                    if (win_cnt == win_len - WIN_W'(1)) begin
                        state <= COMPARE;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end

                COMPARE: begin
                    // Edges from the final MEASURE cycle are already in cnt_a/b.
                    response[bit_idx] <= (cnt_a > cnt_b);
                    tie_mask[bit_idx] <= (cnt_a == cnt_b);
                    cnt_a_last        <= cnt_a;
                    cnt_b_last        <= cnt_b;
                    if (last_bit) begin
                        state <= DONE;
                    end else begin
                        bit_idx    <= bit_idx + IDX_W'(1);
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_engine.sv
module tb_ro_puf_engine;

    localparam int NUM_RO    = 16;
    localparam int SEL_W     = 4;
    localparam int CNT_W     = 16;
    localparam int WIN_W     = 16;
    localparam int RESP_BITS = 8;
    localparam int SAT_CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_RO-1:0]    ro_in;
    logic [NUM_RO-1:0]    ro_in_s;
    logic                 start;
    logic [2*SEL_W-1:0]   challenge;
    logic [WIN_W-1:0]     window;
    logic                 busy;
    logic                 resp_valid;
    logic [RESP_BITS-1:0] response;
    logic [RESP_BITS-1:0] tie_mask;
    logic [CNT_W-1:0]     cnt_a_last;
    logic [CNT_W-1:0]     cnt_b_last;

    logic                 start_s;
    logic [2*SEL_W-1:0]   challenge_s;
    logic [WIN_W-1:0]     window_s;
    logic                 busy_s;
    logic                 resp_valid_s;
    logic [0:0]           response_s;
    logic [0:0]           tie_mask_s;
    logic [SAT_CNT_W-1:0] cnt_a_last_s;
    logic [SAT_CNT_W-1:0] cnt_b_last_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wcyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) wcyc <= wcyc + 1;

    // Oscillator i is a square wave of period 4+2i clk cycles. The second DUT
    // gets the same waves except oscillator 0 toggles every cycle (period 2).
    for (genvar i = 0; i < NUM_RO; i++) begin : g_waves
        assign ro_in[i]   = ((wcyc % (4 + 2 * i)) < (2 + i));
        if (i == 0) begin : g_fast
            assign ro_in_s[i] = ((wcyc % 2) < 1);
        end else begin : g_same
            assign ro_in_s[i] = ro_in[i];
        end
    end

    ro_puf_engine #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .RESP_BITS(RESP_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .challenge(challenge),
        .window(window), .busy(busy), .resp_valid(resp_valid), .response(response),
        .tie_mask(tie_mask), .cnt_a_last(cnt_a_last), .cnt_b_last(cnt_b_last)
    );

    ro_puf_engine #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(SAT_CNT_W), .WIN_W(WIN_W), .RESP_BITS(1)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in_s), .start(start_s), .challenge(challenge_s),
        .window(window_s), .busy(busy_s), .resp_valid(resp_valid_s), .response(response_s),
        .tie_mask(tie_mask_s), .cnt_a_last(cnt_a_last_s), .cnt_b_last(cnt_b_last_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs,
                               input int lo, input int hi);
        checks++;
        assert (int'(obs) >= lo && int'(obs) <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference model: a square wave of period p has floor(w/p) or ceil(w/p)
    // rising edges in any w consecutive cycles; the counter then saturates.
    function automatic int period_of(input int i);
        return 4 + 2 * i;
    endfunction

    function automatic int sat(input int v, input int cw);
        int mx = (1 << cw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int lo_cnt(input int p, input int w, input int cw);
        return sat(w / p, cw);
    endfunction

    function automatic int hi_cnt(input int p, input int w, input int cw);
        return sat((w + p - 1) / p, cw);
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_valid"},    resp_valid, 0);
        check({tag, "_response"}, response,   0);
        check({tag, "_tie"},      tie_mask,   0);
        check({tag, "_cnt_a"},    cnt_a_last, 0);
        check({tag, "_cnt_b"},    cnt_b_last, 0);
    endtask

    // Full challenge on the main DUT; per-bit results are checked one cycle
    // after each COMPARE, i.e. at cycle (k+1)*(W+4)+1 after the start cycle.
    task automatic run(input int sa, input int sb, input int win, input bit poke);
        int s, w, target, a, b, la, ha, lb, hb;
        w = (win == 0) ? 1 : win;
        @(negedge clk);
        challenge = {SEL_W'(sb), SEL_W'(sa)};
        window    = WIN_W'(win);
        start     = 1'b1;
        s         = cyc;
        check("busy_before_start", busy, 0);
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            challenge = 8'($urandom);
            window    = 16'($urandom_range(200, 1000));
        end
        check("busy_after_start", busy, 1);
        for (int k = 0; k < RESP_BITS; k++) begin
            target = (k + 1) * (w + 4) + 1;
            while (cyc - s < target) begin
                @(negedge clk);
                start = (poke && (cyc - s == 7)) ? 1'b1 : 1'b0;
            end
            start = 1'b0;
            a  = (sa + k) % NUM_RO;
            b  = (sb + k) % NUM_RO;
            la = lo_cnt(period_of(a), w, CNT_W);
            ha = hi_cnt(period_of(a), w, CNT_W);
            lb = lo_cnt(period_of(b), w, CNT_W);
            hb = hi_cnt(period_of(b), w, CNT_W);
            check_range($sformatf("cnt_a_bit%0d", k), cnt_a_last, la, ha);
            check_range($sformatf("cnt_b_bit%0d", k), cnt_b_last, lb, hb);
            if (a == b) begin
                check($sformatf("resp_bit%0d", k), response[k], 0);
                check($sformatf("tie_bit%0d", k),  tie_mask[k], 1);
            end else if (ha < lb) begin
                check($sformatf("resp_bit%0d", k), response[k], 0);
                check($sformatf("tie_bit%0d", k),  tie_mask[k], 0);
            end else if (la > hb) begin
                check($sformatf("resp_bit%0d", k), response[k], 1);
                check($sformatf("tie_bit%0d", k),  tie_mask[k], 0);
            end
            check($sformatf("valid_at_bit%0d", k), resp_valid, (k == RESP_BITS - 1) ? 1 : 0);
            check($sformatf("busy_at_bit%0d", k),  busy, 1);
        end
        // Start offered in the resp_valid cycle must be ignored.
        if (poke) begin
            challenge = 8'($urandom);
            start     = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("valid_one_cycle", resp_valid, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int s, sa, sb, w;
        rst_n       = 1'b1;
        start       = 1'b0;
        challenge   = '0;
        window      = '0;
        start_s     = 1'b0;
        challenge_s = '0;
        window_s    = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        check("reset_sat_busy", busy_s, 0);
        check("reset_sat_cnt_a", cnt_a_last_s, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Ascending pairs: A is always the faster oscillator.
        run(0, 1, 64, 1'b1);
        // Swapped base pair.
        run(1, 0, 64, 1'b0);
        // Identical pair: every bit ties.
        run(5, 5, 64, 1'b0);
        check("equal_sel_response", response, 8'h00);
        check("equal_sel_tie", tie_mask, 8'hFF);
        // Index wrap-around.
        run(14, 2, 64, 1'b1);
        // Zero window behaves as a one-cycle window.
        run(3, 9, 0, 1'b0);

        // Reset in the middle of bit 3's measurement window.
        @(negedge clk);
        challenge = {4'd1, 4'd0};
        window    = 16'd64;
        start     = 1'b1;
        s         = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - s < 3 * 68 + 4 + 20) @(negedge clk);
        check("pre_reset_response", response, 8'h07);
        rst_n = 1'b1;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        check_zero_outputs("mid_reset_hold");
        rst_n = 1'b0;
        run(0, 1, 64, 1'b0);

        // Saturation: CNT_W = 4, period-2 oscillator, W = 100.
        @(negedge clk);
        challenge_s = {4'd15, 4'd0};
        window_s    = 16'd100;
        start_s     = 1'b1;
        s           = cyc;
        @(negedge clk);
        start_s = 1'b0;
        while (cyc - s < 1 * (100 + 4) + 1) @(negedge clk);
        check("sat_valid", resp_valid_s, 1);
        check("sat_cnt_a", cnt_a_last_s, 15);
        check_range("sat_cnt_b", cnt_b_last_s, 2, 3);
        check("sat_response", response_s, 1);
        check("sat_tie", tie_mask_s, 0);

        // Randomized challenges and windows.
        for (int r = 0; r < 5; r++) begin
            sa = int'($urandom_range(0, NUM_RO - 1));
            sb = int'($urandom_range(0, NUM_RO - 1));
            w  = int'($urandom_range(0, 48));
            run(sa, sb, w, r[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
